// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity_mode encodings (2'b11 behaves as none)
//   tx_state_e                : frame engine state encoding
//   calc_baud_div()           : clocks per serial bit, truncating division
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous show-ahead FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write din_i (ignored when full)
//   pop_i      : discard head entry (ignored when empty)
//   din_i      : write data
//   dout_o     : head entry, valid whenever !empty_o
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
//   count_o    : registered entry count
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal FIFO through a valid/ready byte port.
//   clk, rst_n    : clock, asynchronous active-low reset (released synchronously)
//   s_valid_i     : producer offers s_data_i
//   s_ready_o     : FIFO not full
//   s_data_i      : DATA_BITS-wide byte, sent LSB first
//   parity_mode_i : 00 none, 01 even, 10 odd, 11 none (sampled per frame)
//   stop2_i       : 1 = two stop bits (sampled per frame)
//   tx_o          : serial line, idle high
//   tx_busy_o     : high from start bit through last stop bit
//   fifo_count_o  : entries stored
//   fifo_empty_o  : FIFO holds nothing
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 20_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DATA_BITS-1:0]          s_data_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          stop2_i,
  output logic                          tx_o,
  output logic                          tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          fifo_empty_o
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BW       = $clog2(BAUD_DIV);
  localparam int unsigned CW       = $clog2(DATA_BITS);

  // Reset asserts immediately and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic                 fifo_full, fifo_empty, pop;
  logic [DATA_BITS-1:0] fifo_dout;

  assign s_ready_o    = !fifo_full;
  assign fifo_empty_o = fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .push_i  (s_valid_i && s_ready_o),
    .pop_i   (pop),
    .din_i   (s_data_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  tx_state_e            state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 last_baud, load;

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;
  assign last_baud = (baud_q == BW'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;
    load      = 1'b0;

    if (state_q != ST_IDLE) baud_d = last_baud ? '0 : baud_q + BW'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (last_baud) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (last_baud) begin
          if (bit_q == CW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + CW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (last_baud) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        // bit_q counts completed stop bits when two are requested.
        if (last_baud) begin
          if (stop2_q && bit_q == '0) begin
            bit_d = CW'(1);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop and start a frame; parity and stop count are frozen here.
    if (load) begin
      pop       = 1'b1;
      state_d   = ST_START;
      baud_d    = '0;
      bit_d     = '0;
      shift_d   = fifo_dout;
      par_en_d  = (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
      par_bit_d = (^fifo_dout) ^ (parity_mode_i == PAR_ODD);
      stop2_d   = stop2_i;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] par;
  logic       st2;

  logic       v8, rdy8, tx8, busy8, emp8;
  logic [7:0] d8;
  logic [4:0] cnt8;
  logic       v5, rdy5, tx5, busy5, emp5;
  logic [4:0] d5;
  logic [4:0] cnt5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .FIFO_DEPTH(16)) u8 (
    .clk(clk), .rst_n(rst_n), .s_valid_i(v8), .s_ready_o(rdy8), .s_data_i(d8),
    .parity_mode_i(par), .stop2_i(st2), .tx_o(tx8), .tx_busy_o(busy8),
    .fifo_count_o(cnt8), .fifo_empty_o(emp8));

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .FIFO_DEPTH(16)) u5 (
    .clk(clk), .rst_n(rst_n), .s_valid_i(v5), .s_ready_o(rdy5), .s_data_i(d5),
    .parity_mode_i(par), .stop2_i(st2), .tx_o(tx5), .tx_busy_o(busy5),
    .fifo_count_o(cnt5), .fifo_empty_o(emp5));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at the sample right after the edge where the start bit began;
  // checks tx against the expected bit and tx_busy high on every clock.
  task automatic check_frame(input string tag, input logic [7:0] d, input int nb,
                             input logic [1:0] pm, input logic s2, input bit use5);
    logic [15:0] bits;
    int          n;
    int          bad;
    logic        p;
    logic        t, b;
    bits = '0;
    n    = 0;
    bad  = 0;
    p    = 1'b0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin
      bits[n] = d[i]; n++;
      p = p ^ d[i];
    end
    if (pm == 2'b01) begin bits[n] = p;  n++; end
    if (pm == 2'b10) begin bits[n] = ~p; n++; end
    bits[n] = 1'b1; n++;
    if (s2) begin bits[n] = 1'b1; n++; end
    for (int c = 0; c < n * DIV; c++) begin
      t = use5 ? tx5 : tx8;
      b = use5 ? busy5 : busy8;
      if (t !== bits[c / DIV] || b !== 1'b1) bad++;
      step();
    end
    chk({tag, " bad_cycles"}, bad, 0);
  endtask

  logic [7:0] pat [20];
  int         idx;
  int         waited;
  int         bad;
  logic       r;

  initial begin
    rst_n = 1'b0; par = 2'b00; st2 = 1'b0;
    v8 = 1'b0; d8 = '0; v5 = 1'b0; d5 = '0;
    for (int i = 0; i < 20; i++) pat[i] = 8'(8'h11 * i + 8'h03);

    // Reset state
    repeat (3) step();
    chk("rst tx", tx8, 1);
    chk("rst busy", busy8, 0);
    chk("rst ready", rdy8, 1);
    chk("rst count", cnt8, 0);
    chk("rst empty", emp8, 1);
    rst_n = 1'b1;
    repeat (4) step();

    // 1: 0x55, no parity, one stop
    v8 = 1'b1; d8 = 8'h55; step(); v8 = 1'b0;
    chk("t1 tx before", tx8, 1);
    chk("t1 count", cnt8, 1);
    step();
    chk("t1 tx falls", tx8, 0);
    check_frame("t1 frame", 8'h55, 8, 2'b00, 1'b0, 1'b0);
    chk("t1 busy end", busy8, 0);
    chk("t1 tx idle", tx8, 1);
    chk("t1 empty", emp8, 1);

    // 2: 0x07 even then odd parity
    par = 2'b01;
    v8 = 1'b1; d8 = 8'h07; step(); v8 = 1'b0; step();
    check_frame("t2 even", 8'h07, 8, 2'b01, 1'b0, 1'b0);
    chk("t2 even busy end", busy8, 0);
    par = 2'b10;
    v8 = 1'b1; d8 = 8'h07; step(); v8 = 1'b0; step();
    check_frame("t2 odd", 8'h07, 8, 2'b10, 1'b0, 1'b0);
    chk("t2 odd busy end", busy8, 0);
    par = 2'b00;

    // 3: 0xA3 with two stops, then 0x3C with one, back to back
    st2 = 1'b1;
    v8 = 1'b1; d8 = 8'hA3; step();
    d8 = 8'h3C; step();
    v8 = 1'b0; st2 = 1'b0;
    chk("t3 tx falls", tx8, 0);
    check_frame("t3 first", 8'hA3, 8, 2'b00, 1'b1, 1'b0);
    check_frame("t3 second", 8'h3C, 8, 2'b00, 1'b0, 1'b0);
    chk("t3 busy end", busy8, 0);

    // 4: hold valid with 20 bytes; 17 accepted
    idx = 0;
    for (int i = 0; i < 25; i++) begin
      v8 = (idx < 20);
      d8 = pat[idx < 20 ? idx : 19];
      r = rdy8;
      step();
      if (r && idx < 20) idx++;
    end
    v8 = 1'b0;
    chk("t4 accepted", idx, 17);
    chk("t4 count full", cnt8, 16);
    chk("t4 ready low", rdy8, 0);
    waited = 0;
    while (cnt8 != 5'd15 && waited < 200) begin
      step();
      waited++;
    end
    chk("t4 pop seen", cnt8, 15);
    chk("t4 ready after pop", rdy8, 1);
    chk("t4 next start", tx8, 0);
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      check_frame($sformatf("t4 frame%0d", k), pat[k], 8, 2'b00, 1'b0, 1'b0);
    end
    chk("t4 busy end", busy8, 0);
    chk("t4 empty end", emp8, 1);

    // 5: five data bits, 0x1B
    v5 = 1'b1; d5 = 5'h1B; step(); v5 = 1'b0; step();
    chk("t5 tx falls", tx5, 0);
    check_frame("t5 frame", 8'h1B, 5, 2'b00, 1'b0, 1'b1);
    chk("t5 busy end", busy5, 0);

    // 6: reset in mid-DATA with 3 queued
    v8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d8 = pat[i]; step();
    end
    v8 = 1'b0;
    repeat (30) step();
    chk("t6 queued", cnt8, 3);
    chk("t6 busy before", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async tx", tx8, 1);
    chk("t6 async busy", busy8, 0);
    chk("t6 async count", cnt8, 0);
    chk("t6 async empty", emp8, 1);
    repeat (3) step();
    #3 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (tx8 !== 1'b1 || busy8 !== 1'b0) bad++;
    end
    chk("t6 idle after reset", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
